// File: rtl/doomsday_pkg.sv
// -----------------------------------------------------------------------------
// doomsday_pkg
// Shared definitions for the doomsday clock top level:
//   - state_e   : display/mode state encoding (also driven onto the mode LEDs)
//   - SEG_OFF   : all segments dark (segments are active-low)
//   - AN_OFF    : all digits disabled (anodes are active-low)
//   - SW_*      : bit positions of the six switches in the filtered vector
//   - target_mode() : fixed-priority resolution of the filtered switches
// -----------------------------------------------------------------------------
package doomsday_pkg;

  typedef enum logic [2:0] {
    S_CLOCK = 3'd0,
    S_UP    = 3'd1,
    S_DOWN  = 3'd2,
    S_TIMER = 3'd3,
    S_ALARM = 3'd4,
    S_BLANK = 3'd7
  } state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  localparam int SW_W    = 6;
  localparam int SW_UP   = 0;  // countup
  localparam int SW_DOWN = 1;  // countdown
  localparam int SW_TSET = 2;  // timerset
  localparam int SW_ASET = 3;  // alarmset
  localparam int SW_TCNT = 4;  // timercount
  localparam int SW_ACNT = 5;  // alarmcount

  // Highest-priority mode switch wins; with none set the clock is shown.
  function automatic state_e target_mode(input logic [SW_W-1:0] f);
    state_e t;
    if (f[SW_UP])        t = S_UP;
    else if (f[SW_DOWN]) t = S_DOWN;
    else if (f[SW_TSET]) t = S_TIMER;
    else if (f[SW_ASET]) t = S_ALARM;
    else                 t = S_CLOCK;
    return t;
  endfunction

endpackage

// File: rtl/vec_debounce.sv
// -----------------------------------------------------------------------------
// vec_debounce
// Two-flop synchronizer followed by a single stability counter shared by all
// bits of the vector. The filtered output only moves once the synchronized
// vector has held the same value for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports:
//   clk     in         system clock
//   rst_ni  in         asynchronous active-low reset
//   raw_i   in  WIDTH  raw (asynchronous) switch inputs
//   filt_o  out WIDTH  debounced vector
// -----------------------------------------------------------------------------
module vec_debounce #(
  parameter int WIDTH           = 6,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16
) (
  input  logic             clk,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] filt_o
);

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] filt_q;
  logic [DB_W-1:0]  cnt_q;
  logic [DB_W-1:0]  cnt_d;

  // sync1_q is what sync2_q becomes next cycle, so comparing the two flags a
  // change of the synchronized vector on the very edge where it happens.
  always_comb begin
    cnt_d = cnt_q;
    if (sync1_q != sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= '0;
      filt_q  <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      // Counter at its last value means sync2_q has been stable long enough.
      if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/display_mode_ctrl.sv
// -----------------------------------------------------------------------------
// display_mode_ctrl
// Mode sequencer and display arbiter. Debounced switches are resolved by
// fixed priority into a target mode; every mode change goes through a blank
// interval of BLANK_CYCLES cycles with the display dark. Sticky run enables
// are driven to the counting units and the matching 7-segment source is
// multiplexed onto the physical display (registered, one cycle behind state).
//
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   countup..alarmcount            raw slide switches
//   seg_<src>[6:0], an_<src>[3:0]  display sources (active-low)
//   seg[6:0], AN[3:0]              registered display drive
//   upstart, downstart,
//   timerstart, alarmstart         sticky run enables
//   timer_mode, alarm_mode         set-mode enables
//   mode[2:0]                      current state encoding
// -----------------------------------------------------------------------------
module display_mode_ctrl
  import doomsday_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int DB_W            = 16,
  parameter int BLANK_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       countup,
  input  logic       countdown,
  input  logic       timerset,
  input  logic       alarmset,
  input  logic       timercount,
  input  logic       alarmcount,
  input  logic [6:0] seg_clk,
  input  logic [6:0] seg_up,
  input  logic [6:0] seg_down,
  input  logic [6:0] seg_timer,
  input  logic [6:0] seg_alarm,
  input  logic [3:0] an_clk,
  input  logic [3:0] an_up,
  input  logic [3:0] an_down,
  input  logic [3:0] an_timer,
  input  logic [3:0] an_alarm,
  output logic [6:0] seg,
  output logic [3:0] AN,
  output logic       upstart,
  output logic       downstart,
  output logic       timerstart,
  output logic       alarmstart,
  output logic       timer_mode,
  output logic       alarm_mode,
  output logic [2:0] mode
);

  localparam int            BW         = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_INIT = BW'(BLANK_CYCLES - 1);

  logic [SW_W-1:0] f_vec;
  state_e          target;

  state_e          state_q;
  logic [BW-1:0]   blank_q;
  logic            upstart_q;
  logic            downstart_q;
  logic            timerstart_q;
  logic            alarmstart_q;
  logic            timer_mode_q;
  logic            alarm_mode_q;
  logic [6:0]      seg_q;
  logic [3:0]      an_q;

  vec_debounce #(
    .WIDTH           (SW_W),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DB_W            (DB_W)
  ) u_debounce (
    .clk    (clk),
    .rst_ni (reset),
    .raw_i  ({alarmcount, timercount, alarmset, timerset, countdown, countup}),
    .filt_o (f_vec)
  );

  always_comb begin
    target = target_mode(f_vec);
  end

  // Mode FSM with its flag registers. Display states are only ever entered
  // from S_BLANK, so "entry" is the S_BLANK exit edge. The target is sampled
  // on that edge, which absorbs any switch activity during the blank.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CLOCK;
      blank_q      <= '0;
      upstart_q    <= 1'b0;
      downstart_q  <= 1'b0;
      timerstart_q <= 1'b0;
      alarmstart_q <= 1'b0;
      timer_mode_q <= 1'b0;
      alarm_mode_q <= 1'b0;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (blank_q == '0) begin
            state_q      <= target;
            timer_mode_q <= (target == S_TIMER);
            alarm_mode_q <= (target == S_ALARM);
            if (target == S_CLOCK) begin
              upstart_q    <= 1'b0;
              downstart_q  <= 1'b0;
              timerstart_q <= 1'b0;
              alarmstart_q <= 1'b0;
            end
            if (target == S_UP)                       upstart_q    <= 1'b1;
            if (target == S_DOWN)                     downstart_q  <= 1'b1;
            if (target == S_TIMER && f_vec[SW_TCNT])  timerstart_q <= 1'b1;
            if (target == S_ALARM && f_vec[SW_ACNT])  alarmstart_q <= 1'b1;
          end else begin
            blank_q <= blank_q - BW'(1);
          end
        end
        // Display states (and any unreachable code, which falls into blank).
        default: begin
          if (target != state_q) begin
            state_q      <= S_BLANK;
            blank_q      <= BLANK_INIT;
            timer_mode_q <= 1'b0;
            alarm_mode_q <= 1'b0;
          end else begin
            if (state_q == S_TIMER && f_vec[SW_TCNT]) timerstart_q <= 1'b1;
            if (state_q == S_ALARM && f_vec[SW_ACNT]) alarmstart_q <= 1'b1;
          end
        end
      endcase
    end
  end

  // Display mux registered from the current state: the visible output trails
  // the state by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_OFF;
      an_q  <= AN_OFF;
    end else begin
      case (state_q)
        S_CLOCK: begin seg_q <= seg_clk;   an_q <= an_clk;   end
        S_UP:    begin seg_q <= seg_up;    an_q <= an_up;    end
        S_DOWN:  begin seg_q <= seg_down;  an_q <= an_down;  end
        S_TIMER: begin seg_q <= seg_timer; an_q <= an_timer; end
        S_ALARM: begin seg_q <= seg_alarm; an_q <= an_alarm; end
        default: begin seg_q <= SEG_OFF;   an_q <= AN_OFF;   end
      endcase
    end
  end

  assign seg        = seg_q;
  assign AN         = an_q;
  assign upstart    = upstart_q;
  assign downstart  = downstart_q;
  assign timerstart = timerstart_q;
  assign alarmstart = alarmstart_q;
  assign timer_mode = timer_mode_q;
  assign alarm_mode = alarm_mode_q;
  assign mode       = state_q;

endmodule

// File: tb/tb_display_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_mode_ctrl
// Directed table, hand-written timing sequences and randomized switch/source
// traffic for display_mode_ctrl with DEBOUNCE_CYCLES=4, BLANK_CYCLES=2. A
// cycle-level behavioural model runs alongside every clock.
// -----------------------------------------------------------------------------
module tb_display_mode_ctrl;

  localparam int DC = 4;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] sw = '0;  // {alarmcount,timercount,alarmset,timerset,countdown,countup}
  logic [6:0] sseg [0:4];
  logic [3:0] san  [0:4];

  logic [6:0] seg;
  logic [3:0] AN;
  logic       upstart, downstart, timerstart, alarmstart, timer_mode, alarm_mode;
  logic [2:0] mode;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  display_mode_ctrl #(
    .DEBOUNCE_CYCLES (DC),
    .DB_W            (4),
    .BLANK_CYCLES    (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .countup    (sw[0]),
    .countdown  (sw[1]),
    .timerset   (sw[2]),
    .alarmset   (sw[3]),
    .timercount (sw[4]),
    .alarmcount (sw[5]),
    .seg_clk    (sseg[0]),
    .seg_up     (sseg[1]),
    .seg_down   (sseg[2]),
    .seg_timer  (sseg[3]),
    .seg_alarm  (sseg[4]),
    .an_clk     (san[0]),
    .an_up      (san[1]),
    .an_down    (san[2]),
    .an_timer   (san[3]),
    .an_alarm   (san[4]),
    .seg        (seg),
    .AN         (AN),
    .upstart    (upstart),
    .downstart  (downstart),
    .timerstart (timerstart),
    .alarmstart (alarmstart),
    .timer_mode (timer_mode),
    .alarm_mode (alarm_mode),
    .mode       (mode)
  );

  // ---------------- behavioural reference model ----------------
  int       m_state;       // 0..4 display modes, 7 blank
  int       m_blank_left;  // blank cycles still to spend
  bit [5:0] m_sync1, m_sync2, m_filt;
  bit [5:0] m_hist[$];     // recent synchronized values
  bit       m_up, m_down, m_ts, m_as, m_tm, m_am;
  bit [6:0] m_seg;
  bit [3:0] m_an;

  function automatic int prio(input bit [5:0] f);
    if (f[0]) return 1;
    if (f[1]) return 2;
    if (f[2]) return 3;
    if (f[3]) return 4;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_blank_left = 0;
    m_sync1 = '0; m_sync2 = '0; m_filt = '0;
    m_hist.delete();
    m_up = 0; m_down = 0; m_ts = 0; m_as = 0; m_tm = 0; m_am = 0;
    m_seg = 7'h7F; m_an = 4'hF;
  endtask

  task automatic model_edge(input bit [5:0] raw, input bit rst_n);
    int       old_state;
    int       tgt;
    bit       entered;
    bit       stable;
    bit [5:0] f_old;
    if (!rst_n) begin
      model_reset();
      return;
    end
    old_state = m_state;
    f_old     = m_filt;
    tgt       = prio(f_old);
    entered   = 0;
    if (old_state == 7) begin
      m_seg = 7'h7F; m_an = 4'hF;
    end else begin
      m_seg = sseg[old_state]; m_an = san[old_state];
    end
    if (old_state == 7) begin
      m_blank_left--;
      if (m_blank_left == 0) begin
        m_state = tgt;
        entered = 1;
      end
    end else if (tgt != old_state) begin
      m_state      = 7;
      m_blank_left = BC;
    end
    if (entered) begin
      if (tgt == 0) begin m_up = 0; m_down = 0; m_ts = 0; m_as = 0; end
      if (tgt == 1) m_up = 1;
      if (tgt == 2) m_down = 1;
    end
    if (m_state == 3 && f_old[4]) m_ts = 1;
    if (m_state == 4 && f_old[5]) m_as = 1;
    m_tm = (m_state == 3);
    m_am = (m_state == 4);
    // Filter: accept once the synchronized value held for DC consecutive cycles.
    m_hist.push_back(m_sync2);
    if (m_hist.size() > DC) void'(m_hist.pop_front());
    stable = (m_hist.size() == DC);
    foreach (m_hist[i]) if (m_hist[i] != m_sync2) stable = 0;
    if (stable) m_filt = m_sync2;
    m_sync2 = m_sync1;
    m_sync1 = raw;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] flags();
    return {upstart, downstart, timerstart, alarmstart, timer_mode, alarm_mode};
  endfunction

  task automatic step(input bit [5:0] s, input bit r, input bit rnd_src);
    @(negedge clk);
    sw    = s;
    reset = r;
    if (rnd_src) begin
      for (int i = 0; i < 5; i++) begin
        sseg[i] = 7'($urandom);
        san[i]  = 4'($urandom);
      end
    end
    @(posedge clk);
    model_edge(s, r);
    #1;
    chk("model", {12'd0, seg, AN, mode, flags()},
        {12'd0, m_seg, m_an, 3'(m_state), m_up, m_down, m_ts, m_as, m_tm, m_am});
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit [5:0] sw;
    int       hold;
    bit [2:0] mode;
    bit [5:0] flags;  // {up,down,tstart,astart,tmode,amode}
    bit [6:0] seg;
    bit [3:0] an;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{6'h00,  8, 3'd0, 6'b000000, 7'h01, 4'h1};
    tbl[1]  = '{6'h01, 12, 3'd1, 6'b100000, 7'h02, 4'h2};
    tbl[2]  = '{6'h03, 12, 3'd1, 6'b100000, 7'h02, 4'h2};
    tbl[3]  = '{6'h02, 12, 3'd2, 6'b110000, 7'h03, 4'h3};
    tbl[4]  = '{6'h00, 12, 3'd0, 6'b000000, 7'h01, 4'h1};
    tbl[5]  = '{6'h04, 12, 3'd3, 6'b000010, 7'h04, 4'h4};
    tbl[6]  = '{6'h14, 12, 3'd3, 6'b001010, 7'h04, 4'h4};
    tbl[7]  = '{6'h04, 12, 3'd3, 6'b001010, 7'h04, 4'h4};
    tbl[8]  = '{6'h0A, 12, 3'd2, 6'b011000, 7'h03, 4'h3};
    tbl[9]  = '{6'h08, 12, 3'd4, 6'b011001, 7'h05, 4'h5};
    tbl[10] = '{6'h28, 12, 3'd4, 6'b011101, 7'h05, 4'h5};
    tbl[11] = '{6'h00, 12, 3'd0, 6'b000000, 7'h01, 4'h1};

    for (int i = 0; i < 5; i++) begin
      sseg[i] = 7'(i + 1);
      san[i]  = 4'(i + 1);
    end
    model_reset();

    // Reset state
    step(6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b0, 1'b0);
    chk("reset_out", {seg, AN, mode, flags()}, {7'h7F, 4'hF, 3'd0, 6'b0});

    // Directed table
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < tbl[i].hold; k++) step(tbl[i].sw, 1'b1, 1'b0);
      chk($sformatf("row%0d", i), {mode, flags(), seg, AN},
          {tbl[i].mode, tbl[i].flags, tbl[i].seg, tbl[i].an});
    end

    // countup held: filtered at +6, blank for 2, UP at +9, seg_up at +10
    for (int k = 1; k <= 10; k++) begin
      step(6'h01, 1'b1, 1'b0);
      if (k == 6) chk("up_k6_mode", mode, 3'd0);
      if (k == 7) chk("up_k7_mode", mode, 3'd7);
      if (k == 8) chk("up_k8_mode", mode, 3'd7);
      if (k == 9) chk("up_k9", {mode, upstart, seg}, {3'd1, 1'b1, 7'h7F});
      if (k == 10) chk("up_k10_seg", seg, 7'h02);
    end
    for (int k = 0; k < 12; k++) step(6'h00, 1'b1, 1'b0);
    chk("back_clock", {mode, flags()}, {3'd0, 6'b0});

    // 3-cycle glitch must be rejected
    for (int k = 0; k < 13; k++) begin
      step((k < 3) ? 6'h01 : 6'h00, 1'b1, 1'b0);
      chk("glitch", {mode, upstart}, {3'd0, 1'b0});
    end

    // Reset asserted in the middle of a blank
    for (int k = 0; k < 7; k++) step(6'h02, 1'b1, 1'b0);
    chk("pre_reset_blank", mode, 3'd7);
    reset = 1'b0;
    #1;
    chk("async_reset", {seg, AN, mode, flags()}, {7'h7F, 4'hF, 3'd0, 6'b0});
    model_reset();
    step(6'h00, 1'b0, 1'b0);
    step(6'h00, 1'b1, 1'b0);
    step(6'h00, 1'b1, 1'b0);
    chk("post_reset_seg", {seg, AN}, {7'h01, 4'h1});

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      bit [5:0] s;
      int       hold;
      s    = 6'($urandom) & 6'($urandom);
      hold = $urandom_range(1, 12);
      for (int k = 0; k < hold; k++) step(s, ($urandom_range(0, 299) != 0), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
